four_bit_serial_adder: RTL and testbench

// - Bit-serial adder for two 4-bit unsigned operands, producing a 5-bit sum (carry in out[4]).
// - Reset loads the operands into shift registers and clears the carry; one full-adder step runs per clock, LSB first.
// - The result is valid after 4 clocks. Internal single-bit nets are exported as ports for debug and visibility.
//

---
 rtl/four_bit_serial_adder.sv | 128 ++++++++++++
 tb/tb_four_bit_serial_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/four_bit_serial_adder.sv
// ---------------------------------------------------------------------------
// four_bit_serial_adder
//
// Purpose:
//   Bit-serial adder for two 4-bit unsigned operands. A reset edge loads the
//   operands into shift registers and clears the carry. Each following clock
//   performs one full-adder step, LSB first. After four steps the 5-bit sum
//   (final carry in out[4]) is on out and all state is frozen until the next
//   reset. The internal single-bit nets are exported for debug visibility.
//
// Configuration:
//   SERIAL_ADDER_DONE_EN - when defined, adds a registered 'done' output. It
//                          rises on the edge where counter reaches 4 and is
//                          cleared by reset.
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset    in   1  synchronous, active-high; loads a/b, clears carry/out/counter
//   a        in   4  operand A, sampled only while reset=1
//   b        in   4  operand B, sampled only while reset=1
//   out      out  5  out[3:0] sum shift register, out[4] final carry
//   a0       out  1  LSB of the A shift register
//   b0       out  1  LSB of the B shift register
//   s        out  1  combinational sum bit a0 ^ b0 ^ cin
//   cin      out  1  carry register (carry into the current bit)
//   cout     out  1  combinational carry out of the current bit
//   counter  out  4  bits processed, 0..4, saturating at 4
//   done     out  1  completion flag (SERIAL_ADDER_DONE_EN only)
// ---------------------------------------------------------------------------
module four_bit_serial_adder (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] out,
    output logic       a0,
    output logic       b0,
    output logic       s,
    output logic       cin,
    output logic       cout,
    output logic [3:0] counter
`ifdef SERIAL_ADDER_DONE_EN
    ,
    output logic       done
`endif
);

    localparam logic [3:0] NUM_STEPS = 4'd4;
    localparam logic [3:0] LAST_STEP = 4'd3;

    logic [3:0] sra_r;
    logic [3:0] srb_r;
    logic       cin_r;
    logic [4:0] out_r;
    logic [3:0] counter_r;
    logic       sum_s;
    logic       cout_s;
    logic       step_s;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        fa_sum = x ^ y ^ ci;
    endfunction

    // Full-adder carry-out bit.
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        fa_carry = (x & y) | (ci & (x ^ y));
    endfunction

    // Current full-adder step and whether a step is still pending.
    always_comb begin
        sum_s  = fa_sum(sra_r[0], srb_r[0], cin_r);
        cout_s = fa_carry(sra_r[0], srb_r[0], cin_r);
        step_s = (counter_r < NUM_STEPS);
    end

    // Operand shift registers, carry, result and step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sra_r     <= a;
            srb_r     <= b;
            cin_r     <= 1'b0;
            out_r     <= 5'b0_0000;
            counter_r <= 4'd0;
        end else if (step_s) begin
            sra_r      <= {1'b0, sra_r[3:1]};
            srb_r      <= {1'b0, srb_r[3:1]};
            cin_r      <= cout_s;
            // Sum bits enter at bit 3 so that after four steps bit 0 is the LSB.
            out_r[3:0] <= {sum_s, out_r[3:1]};
            // The final carry is only committed on the last step.
            out_r[4]   <= (counter_r == LAST_STEP) ? cout_s : 1'b0;
            counter_r  <= counter_r + 4'd1;
        end else begin
            sra_r     <= sra_r;
            srb_r     <= srb_r;
            cin_r     <= cin_r;
            out_r     <= out_r;
            counter_r <= counter_r;
        end
    end

`ifdef SERIAL_ADDER_DONE_EN
    logic done_r;

    // Completion flag, set on the edge where the counter reaches its limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r <= 1'b0;
        end else if (step_s && (counter_r == LAST_STEP)) begin
            done_r <= 1'b1;
        end else begin
            done_r <= done_r;
        end
    end

    assign done = done_r;
`endif

    assign out     = out_r;
    assign a0      = sra_r[0];
    assign b0      = srb_r[0];
    assign s       = sum_s;
    assign cin     = cin_r;
    assign cout    = cout_s;
    assign counter = counter_r;

endmodule

// File: tb/tb_four_bit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_four_bit_serial_adder
//
// Directed-vector bench for four_bit_serial_adder. The stimulus process drives
// one clock cycle at a time and, right after each rising edge, pushes the
// hand-computed expected state into a queue. A monitor on the falling edge
// pops each entry and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_four_bit_serial_adder;

    logic       clk;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] out;
    logic       a0;
    logic       b0;
    logic       s;
    logic       cin;
    logic       cout;
    logic [3:0] counter;
`ifdef SERIAL_ADDER_DONE_EN
    logic       done;
`endif

    typedef struct {
        logic [4:0] out;
        logic [3:0] cnt;
        logic       cin;
        logic       hold;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    four_bit_serial_adder dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .out     (out),
        .a0      (a0),
        .b0      (b0),
        .s       (s),
        .cin     (cin),
        .cout    (cout),
        .counter (counter)
`ifdef SERIAL_ADDER_DONE_EN
        ,
        .done    (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the DUT state after each edge with the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("out", out, e.out);
            check("counter", {1'b0, counter}, {1'b0, e.cnt});
            check("cin", {4'b0, cin}, {4'b0, e.cin});
            if (e.hold) begin
                check("hold_a0", {4'b0, a0}, 5'd0);
                check("hold_b0", {4'b0, b0}, 5'd0);
                check("hold_s", {4'b0, s}, {4'b0, e.cin});
                check("hold_cout", {4'b0, cout}, 5'd0);
            end
`ifdef SERIAL_ADDER_DONE_EN
            check("done", {4'b0, done}, {4'b0, e.done});
`endif
        end
    end

    // One clock cycle: drive inputs, take the edge, queue the expected result.
    task automatic cyc(input logic rst, input logic [3:0] ta, input logic [3:0] tb_v,
                       input logic [4:0] eo, input logic [3:0] ec, input logic ecin);
        exp_t e;
        reset = rst;
        a     = ta;
        b     = tb_v;
        @(posedge clk);
        e.out  = eo;
        e.cnt  = ec;
        e.cin  = ecin;
        e.hold = (ec == 4'd4);
        e.done = (ec == 4'd4);
        q.push_back(e);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a     = 4'd0;
        b     = 4'd0;

        // Sum: 12 + 6 = 18, then held through cycle 10.
        cyc(1'b1, 4'd12, 4'd6, 5'b00000, 4'd0, 1'b0);
        cyc(1'b0, 4'd12, 4'd6, 5'b00000, 4'd1, 1'b0);
        cyc(1'b0, 4'd12, 4'd6, 5'b01000, 4'd2, 1'b0);
        cyc(1'b0, 4'd12, 4'd6, 5'b00100, 4'd3, 1'b1);
        cyc(1'b0, 4'd12, 4'd6, 5'b10010, 4'd4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 4'd12, 4'd6, 5'b10010, 4'd4, 1'b1);
        end

        // Max: 15 + 15 = 30, carry stays 1 after completion.
        cyc(1'b1, 4'd15, 4'd15, 5'b00000, 4'd0, 1'b0);
        cyc(1'b0, 4'd15, 4'd15, 5'b00000, 4'd1, 1'b1);
        cyc(1'b0, 4'd15, 4'd15, 5'b01000, 4'd2, 1'b1);
        cyc(1'b0, 4'd15, 4'd15, 5'b01100, 4'd3, 1'b1);
        cyc(1'b0, 4'd15, 4'd15, 5'b11110, 4'd4, 1'b1);
        cyc(1'b0, 4'd15, 4'd15, 5'b11110, 4'd4, 1'b1);

        // Zero: 0 + 0, counter walks 0..4 and saturates.
        cyc(1'b1, 4'd0, 4'd0, 5'b00000, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 5'b00000, 4'd1, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 5'b00000, 4'd2, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 5'b00000, 4'd3, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 5'b00000, 4'd4, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 5'b00000, 4'd4, 1'b0);

        // Carry ripple: 9 + 7 = 16, carry 1 after every step.
        cyc(1'b1, 4'd9, 4'd7, 5'b00000, 4'd0, 1'b0);
        cyc(1'b0, 4'd9, 4'd7, 5'b00000, 4'd1, 1'b1);
        cyc(1'b0, 4'd9, 4'd7, 5'b00000, 4'd2, 1'b1);
        cyc(1'b0, 4'd9, 4'd7, 5'b00000, 4'd3, 1'b1);
        cyc(1'b0, 4'd9, 4'd7, 5'b10000, 4'd4, 1'b1);

        // Abort: start 12 + 6, reload 3 + 5 after two steps -> 8.
        cyc(1'b1, 4'd12, 4'd6, 5'b00000, 4'd0, 1'b0);
        cyc(1'b0, 4'd12, 4'd6, 5'b00000, 4'd1, 1'b0);
        cyc(1'b0, 4'd12, 4'd6, 5'b01000, 4'd2, 1'b0);
        cyc(1'b1, 4'd3, 4'd5, 5'b00000, 4'd0, 1'b0);
        cyc(1'b0, 4'd3, 4'd5, 5'b00000, 4'd1, 1'b1);
        cyc(1'b0, 4'd3, 4'd5, 5'b00000, 4'd2, 1'b1);
        cyc(1'b0, 4'd3, 4'd5, 5'b00000, 4'd3, 1'b1);
        cyc(1'b0, 4'd3, 4'd5, 5'b01000, 4'd4, 1'b0);

        // Reset held three cycles: last load (9 + 7) wins, counter stays 0.
        // Then operands change every step: result is still 16.
        cyc(1'b1, 4'd15, 4'd15, 5'b00000, 4'd0, 1'b0);
        cyc(1'b1, 4'd1, 4'd2, 5'b00000, 4'd0, 1'b0);
        cyc(1'b1, 4'd9, 4'd7, 5'b00000, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 5'b00000, 4'd1, 1'b1);
        cyc(1'b0, 4'd15, 4'd15, 5'b00000, 4'd2, 1'b1);
        cyc(1'b0, 4'd5, 4'd10, 5'b00000, 4'd3, 1'b1);
        cyc(1'b0, 4'd3, 4'd3, 5'b10000, 4'd4, 1'b1);
        cyc(1'b0, 4'd8, 4'd1, 5'b10000, 4'd4, 1'b1);

        // Reset after completion clears everything (and done).
        cyc(1'b1, 4'd1, 4'd1, 5'b00000, 4'd0, 1'b0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
